// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a synchronous FIFO and sends each as a UART frame (start, 8 data LSB first, optional parity, stop)
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   enable            allows new frames to start; a frame in flight always completes
//   fifo_empty        FIFO empty flag, sampled only while idle
//   fifo_rd_en        one-cycle pop pulse, one per frame
//   fifo_data         FIFO read data, valid the cycle after the pop is sampled
//   tx                serial line, idle high
//   busy              high from the pop through the last stop-bit cycle
//   frame_done        one-cycle pulse after the last stop-bit cycle
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_WIDTH    = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    input  logic [7:0] fifo_data,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);
    typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, PARITY, STOP} state_t;
    state_t state, state_n;
    logic [CNT_WIDTH-1:0] cnt, cnt_n;
    logic [2:0] idx, idx_n;
    logic [7:0] sh, sh_n;
    logic par, par_n, tx_n, rd_n, busy_n, done_n, last;
    assign last = cnt == CNT_WIDTH'(CLKS_PER_BIT - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            sh         <= '0;
            par        <= 1'b0;
            tx         <= 1'b1;
            fifo_rd_en <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            sh         <= sh_n;
            par        <= par_n;
            tx         <= tx_n;
            fifo_rd_en <= rd_n;
            busy       <= busy_n;
            frame_done <= done_n;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        sh_n    = sh;
        par_n   = par;
        tx_n    = tx;
        rd_n    = 1'b0;
        busy_n  = busy;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (enable && !fifo_empty) begin
                    rd_n    = 1'b1;
                    busy_n  = 1'b1;
                    state_n = POP;
                end
            end
            POP: state_n = LOAD;
            LOAD: begin
                sh_n    = fifo_data;
                par_n   = ^fifo_data;
                tx_n    = 1'b0;
                cnt_n   = '0;
                state_n = START;
            end
            START, DATA, PARITY, STOP: begin
                // each bit is held for CLKS_PER_BIT cycles; decisions happen on the last one
                cnt_n = last ? '0 : cnt + 1'b1;
                if (last) begin
                    case (state)
                        START: begin
                            tx_n    = sh[0];
                            sh_n    = sh >> 1;
                            idx_n   = '0;
                            state_n = DATA;
                        end
                        DATA: begin
                            if (idx == 3'd7) begin
                                tx_n    = (PARITY_EN != 0) ? (par ^ (PARITY_ODD != 0)) : 1'b1;
                                state_n = (PARITY_EN != 0) ? PARITY : STOP;
                            end else begin
                                idx_n = idx + 3'd1;
                                tx_n  = sh[0];
                                sh_n  = sh >> 1;
                            end
                        end
                        PARITY: begin
                            tx_n    = 1'b1;
                            state_n = STOP;
                        end
                        default: begin
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                            state_n = IDLE;
                        end
                    endcase
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed bench for fifo_uart_tx with a FIFO model and even/odd parity instances
module tb_fifo_uart_tx;
    localparam int CPB = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en0 = 1'b0, en_p = 1'b0;
    logic fe0 = 1'b1, fe_p = 1'b1;
    logic [7:0] d0 = 8'h00, d_p = 8'h00;
    logic tx_v[3], rd_v[3], busy_v[3], fd_v[3];
    logic [7:0] q[$];
    int pops = 0, uf = 0;
    int fdc[3];
    int n_chk = 0, n_err = 0;
    always #5 clk = ~clk;
    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .CNT_WIDTH(4), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
        .clk(clk), .rst(rst), .enable(en0), .fifo_empty(fe0), .fifo_rd_en(rd_v[0]),
        .fifo_data(d0), .tx(tx_v[0]), .busy(busy_v[0]), .frame_done(fd_v[0]));
    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .CNT_WIDTH(4), .PARITY_EN(1), .PARITY_ODD(0)) dut_e (
        .clk(clk), .rst(rst), .enable(en_p), .fifo_empty(fe_p), .fifo_rd_en(rd_v[1]),
        .fifo_data(d_p), .tx(tx_v[1]), .busy(busy_v[1]), .frame_done(fd_v[1]));
    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .CNT_WIDTH(4), .PARITY_EN(1), .PARITY_ODD(1)) dut_o (
        .clk(clk), .rst(rst), .enable(en_p), .fifo_empty(fe_p), .fifo_rd_en(rd_v[2]),
        .fifo_data(d_p), .tx(tx_v[2]), .busy(busy_v[2]), .frame_done(fd_v[2]));
    // FIFO model: data appears the cycle after a pop is sampled; empty flag lags one edge
    always @(posedge clk) begin
        if (rd_v[0]) begin
            if (q.size() == 0) uf <= uf + 1;
            else d0 <= q.pop_front();
            pops <= pops + 1;
        end
        fe0 <= (q.size() == 0);
    end
    always @(negedge clk)
        for (int i = 0; i < 3; i++) if (fd_v[i]) fdc[i] <= fdc[i] + 1;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // Receive one frame on instance d; act 1 drops enable, act 2 asserts reset at bit-sample act_at
    task automatic recv(input int d, input logic [7:0] b, input int act_at, input int act, output int w);
        int nb, lat, rdn, bsy, herr, k;
        logic p;
        logic [10:0] bits, obs;
        nb = (d == 0) ? 10 : 11;
        p = (d == 1) ? ^b : ~^b;
        bits = (d == 0) ? {1'b0, 1'b1, b, 1'b0} : {1'b1, p, b, 1'b0};
        obs = '0;
        herr = 0;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!rd_v[d] && w < 200);
        if (!rd_v[d]) begin
            check("rd_timeout", 0, 1);
            return;
        end
        if (d > 0) fe_p = 1'b1;
        rdn = 1;
        bsy = busy_v[d];
        lat = 0;
        while (tx_v[d] && lat < 10) begin
            @(negedge clk);
            lat++;
            rdn += rd_v[d];
            bsy += busy_v[d];
        end
        check("tx_latency", lat, 2);
        for (int i = 0; i < nb; i++) begin
            for (int j = 0; j < CPB; j++) begin
                if (i > 0 || j > 0) begin
                    @(negedge clk);
                    rdn += rd_v[d];
                    bsy += busy_v[d];
                end
                k = i * CPB + j;
                if (act == 1 && k == act_at) en0 = 1'b0;
                if (act == 2 && k == act_at) begin
                    check("pre_rst_tx", tx_v[d], 0);
                    rst = 1'b1;
                    #1;
                    check("rst_tx", tx_v[d], 1);
                    check("rst_busy", busy_v[d], 0);
                    repeat (3) @(negedge clk);
                    rst = 1'b0;
                    return;
                end
                if (j == 0) obs[i] = tx_v[d];
                else if (tx_v[d] !== obs[i]) herr++;
            end
        end
        check("frame_bits", obs, bits);
        check("bit_hold", herr, 0);
        check("rd_pulses", rdn, 1);
        check("busy_len", bsy, 2 + nb * CPB);
        @(negedge clk);
        check("frame_done", fd_v[d], 1);
        check("busy_end", busy_v[d], 0);
    endtask
    initial begin
        int w, w2, cnt_rd, cnt_lo, f0, p0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx_v[0], 1);
        check("rst_rd", rd_v[0], 0);
        check("rst_busy", busy_v[0], 0);
        check("rst_fd", fd_v[0], 0);
        rst = 1'b0;
        en0 = 1'b1;
        cnt_rd = 0;
        cnt_lo = 0;
        repeat (100) begin
            @(negedge clk);
            cnt_rd += rd_v[0];
            cnt_lo += !tx_v[0];
        end
        check("empty_rd", cnt_rd, 0);
        check("empty_tx_low", cnt_lo, 0);
        q.push_back(8'hA5);
        f0 = fdc[0];
        recv(0, 8'hA5, -1, 0, w);
        repeat (10) @(negedge clk);
        check("fd_count", fdc[0] - f0, 1);
        p0 = pops;
        q.push_back(8'h00);
        q.push_back(8'hFF);
        q.push_back(8'h3C);
        recv(0, 8'h00, -1, 0, w);
        recv(0, 8'hFF, -1, 0, w);
        check("gap1", w + 2, 3);
        recv(0, 8'h3C, -1, 0, w);
        check("gap2", w + 2, 3);
        repeat (50) @(negedge clk);
        check("pops3", pops - p0, 3);
        check("fifo_empty3", q.size(), 0);
        d_p = 8'h07;
        fe_p = 1'b0;
        en_p = 1'b1;
        fork
            recv(1, 8'h07, -1, 0, w);
            recv(2, 8'h07, -1, 0, w2);
        join
        en_p = 1'b0;
        q.push_back(8'h55);
        q.push_back(8'h66);
        recv(0, 8'h55, 5 * CPB + 1, 1, w);
        cnt_rd = 0;
        repeat (40) begin
            @(negedge clk);
            cnt_rd += rd_v[0];
        end
        check("dis_rd", cnt_rd, 0);
        check("dis_queued", q.size(), 1);
        en0 = 1'b1;
        recv(0, 8'h66, -1, 0, w);
        q.push_back(8'h81);
        q.push_back(8'h42);
        recv(0, 8'h81, 4 * CPB + 1, 2, w);
        recv(0, 8'h42, -1, 0, w);
        repeat (50) @(negedge clk);
        check("pops_total", pops, 8);
        check("fifo_empty_end", q.size(), 0);
        check("underflow", uf, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
